// File: rtl/product_acc_pkg.sv
// ---------------------------------------------------------------------------
// product_acc_pkg
// Shared definitions for the product accumulator slice.
//   - acc_state_e : accumulator FSM states (ACCUM collects beats, HOLD
//                   presents a finished sum until it is taken)
//   - *_DEF       : default widths for product, accumulator and term counter
//   - max_val()   : all-ones value of a given width (saturation limits)
// ---------------------------------------------------------------------------
package product_acc_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;

  localparam int PROD_W_DEF = 32;
  localparam int ACC_W_DEF  = 40;
  localparam int CNT_W_DEF  = 8;

  // All-ones value of 'width' bits, computed on 64 bits so that callers
  // can truncate it to their own width with a cast.
  function automatic logic [63:0] max_val(input int unsigned width);
    if (width >= 64) begin
      return '1;
    end
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/product_accumulator_adder.sv
// ---------------------------------------------------------------------------
// acc_adder
// Purely combinational ACC_W-bit adder with carry-out. Adds a zero-extended
// PROD_W-bit product to the running accumulator.
// Build option: PRODUCT_ACCUMULATOR_SAT_EN
//   defined   -> on carry-out the sum is clamped to all ones
//   undefined -> the sum wraps modulo 2^ACC_W
// The carry-out is reported in both builds.
// Ports:
//   acc_i    [ACC_W-1:0]  current accumulator value
//   addend_i [PROD_W-1:0] unsigned product to add
//   sum_o    [ACC_W-1:0]  next accumulator value
//   carry_o               carry out of the ACC_W-bit add
// ---------------------------------------------------------------------------
module acc_adder
  import product_acc_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] addend_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              carry_o
);

  // One extra bit catches the carry; ACC_W >= PROD_W so the cast only
  // ever zero-extends the product.
  logic [ACC_W:0] full_sum;

  always_comb begin
    full_sum = {1'b0, acc_i} + (ACC_W+1)'(addend_i);
  end

  assign carry_o = full_sum[ACC_W];

`ifdef PRODUCT_ACCUMULATOR_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(max_val(ACC_W));

  // Once clamped, any further non-zero addend carries again and a zero
  // addend leaves the value alone, so saturation is sticky by itself.
  assign sum_o = carry_o ? ACC_MAX : full_sum[ACC_W-1:0];
`else
  assign sum_o = full_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
// Sums a vector of unsigned products (one beat per cycle, delimited by
// in_last) into a dot-product result presented on a valid/ready output,
// together with a saturating term count and a sticky overflow flag.
// Build option: PRODUCT_ACCUMULATOR_SAT_EN (see acc_adder) selects
// saturating instead of wrapping accumulation.
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   clear                   synchronous abort of partial/pending vector
//   in_valid/in_ready       product beat handshake
//   in_product [PROD_W-1:0] unsigned product
//   in_last                 final beat of the vector
//   out_valid/out_ready     result handshake
//   out_sum [ACC_W-1:0]     vector sum
//   out_count [CNT_W-1:0]   number of terms (saturating)
//   out_ovf                 sum exceeded 2^ACC_W-1 within the vector
// ---------------------------------------------------------------------------
module product_accumulator
  import product_acc_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(max_val(CNT_W));

  acc_state_e        state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [ACC_W-1:0]  out_sum_q, out_sum_d;
  logic [CNT_W-1:0]  out_count_q, out_count_d;
  logic              out_ovf_q, out_ovf_d;

  logic [ACC_W-1:0]  add_sum;
  logic              add_carry;
  logic [CNT_W-1:0]  cnt_inc;

  acc_adder #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_adder (
    .acc_i    (acc_q),
    .addend_i (in_product),
    .sum_o    (add_sum),
    .carry_o  (add_carry)
  );

  // Handshake flags come straight from the state register, so neither
  // in_ready nor out_valid has a combinational path from any input.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

  // Term counter sticks at its maximum instead of wrapping.
  always_comb begin
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Next-state logic. clear overrides everything; the output registers are
  // deliberately left alone by clear so they keep their last values.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    if (clear) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            if (in_last) begin
              // Publish the total including this beat and start the next
              // vector from zero on the same edge.
              out_sum_d   = add_sum;
              out_count_d = cnt_inc;
              out_ovf_d   = ovf_q | add_carry;
              acc_d       = '0;
              cnt_d       = '0;
              ovf_d       = 1'b0;
              state_d     = HOLD;
            end else begin
              acc_d = add_sum;
              cnt_d = cnt_inc;
              ovf_d = ovf_q | add_carry;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = ACCUM;
          end
        end
        default: begin
          state_d = ACCUM;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// ---------------------------------------------------------------------------
// tb_product_accumulator
// Directed bench for product_accumulator. Two instances share all inputs:
// the default 40-bit build and a 33-bit accumulator build used to reach
// overflow with few beats. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_product_accumulator;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        inValid;
  logic [31:0] inProduct;
  logic        inLast;
  logic        outReady;

  logic        inReady;
  logic        outValid;
  logic [39:0] outSum;
  logic [7:0]  outCount;
  logic        outOvf;

  logic        inReady33;
  logic        outValid33;
  logic [32:0] outSum33;
  logic [7:0]  outCount33;
  logic        outOvf33;

  int checks = 0;
  int errors = 0;

  product_accumulator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .in_product (inProduct),
    .in_last    (inLast),
    .out_valid  (outValid),
    .out_ready  (outReady),
    .out_sum    (outSum),
    .out_count  (outCount),
    .out_ovf    (outOvf)
  );

  product_accumulator #(.PROD_W(32), .ACC_W(33), .CNT_W(8)) dut33 (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (inValid),
    .in_ready   (inReady33),
    .in_product (inProduct),
    .in_last    (inLast),
    .out_valid  (outValid33),
    .out_ready  (outReady),
    .out_sum    (outSum33),
    .out_count  (outCount33),
    .out_ovf    (outOvf33)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present one beat and step past the edge that takes it.
  task automatic drive(input logic [31:0] p, input logic last);
    inValid   = 1'b1;
    inProduct = p;
    inLast    = last;
    @(posedge clk);
    #1;
  endtask

  // Idle cycles with junk payload that must be ignored.
  task automatic idle(input int n);
    inValid   = 1'b0;
    inLast    = 1'b1;
    inProduct = 32'hDEAD_BEEF;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %0h expected 0", outValid); end
    checks++; if (outSum !== 40'd0) begin errors++; $display("[TB] FAIL reset_out_sum: got %0h expected 0", outSum); end
    checks++; if (outCount !== 8'd0) begin errors++; $display("[TB] FAIL reset_out_count: got %0h expected 0", outCount); end
    checks++; if (outOvf !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_ovf: got %0h expected 0", outOvf); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %0h expected 1", inReady); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_basic();
    outReady = 1'b1;
    drive(32'd6, 1'b0);
    drive(32'd20, 1'b0);
    drive(32'd100, 1'b1);
    inValid = 1'b0;
    checks++; if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid: got %0h expected 1", outValid); end
    checks++; if (outSum !== 40'd126) begin errors++; $display("[TB] FAIL basic_sum: got %0d expected 126", outSum); end
    checks++; if (outCount !== 8'd3) begin errors++; $display("[TB] FAIL basic_count: got %0d expected 3", outCount); end
    checks++; if (outOvf !== 1'b0) begin errors++; $display("[TB] FAIL basic_ovf: got %0h expected 0", outOvf); end
    checks++; if (inReady !== 1'b0) begin errors++; $display("[TB] FAIL basic_ready_hold: got %0h expected 0", inReady); end
    idle(1);
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_drop: got %0h expected 0", outValid); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL basic_ready_back: got %0h expected 1", inReady); end
    checks++; if (outSum !== 40'd126) begin errors++; $display("[TB] FAIL basic_sum_kept: got %0d expected 126", outSum); end
  endtask

  task automatic test_single();
    outReady = 1'b1;
    drive(32'hFFFF_FFFF, 1'b1);
    inValid = 1'b0;
    checks++; if (outSum !== 40'h00_FFFF_FFFF) begin errors++; $display("[TB] FAIL single_sum: got %0h expected ffffffff", outSum); end
    checks++; if (outCount !== 8'd1) begin errors++; $display("[TB] FAIL single_count: got %0d expected 1", outCount); end
    idle(1);
    drive(32'd5, 1'b0);
    drive(32'd7, 1'b1);
    inValid = 1'b0;
    checks++; if (outSum !== 40'd12) begin errors++; $display("[TB] FAIL after_single_sum: got %0d expected 12", outSum); end
    checks++; if (outCount !== 8'd2) begin errors++; $display("[TB] FAIL after_single_count: got %0d expected 2", outCount); end
    checks++; if (outOvf !== 1'b0) begin errors++; $display("[TB] FAIL after_single_ovf: got %0h expected 0", outOvf); end
    idle(1);
  endtask

  task automatic test_gaps();
    outReady = 1'b1;
    drive(32'd1, 1'b0);
    idle(2);
    drive(32'd2, 1'b0);
    idle(1);
    drive(32'd3, 1'b1);
    inValid = 1'b0;
    checks++; if (outSum !== 40'd6) begin errors++; $display("[TB] FAIL gaps_sum: got %0d expected 6", outSum); end
    checks++; if (outCount !== 8'd3) begin errors++; $display("[TB] FAIL gaps_count: got %0d expected 3", outCount); end
    idle(1);
  endtask

  task automatic test_back_to_back_hold();
    outReady = 1'b0;
    drive(32'd3, 1'b0);
    drive(32'd4, 1'b1);
    // Keep offering beats while the result is stalled.
    inProduct = 32'd99;
    inLast    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (inReady !== 1'b0) begin errors++; $display("[TB] FAIL hold_ready[%0d]: got %0h expected 0", i, inReady); end
      checks++; if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL hold_valid[%0d]: got %0h expected 1", i, outValid); end
      checks++; if (outSum !== 40'd7) begin errors++; $display("[TB] FAIL hold_sum[%0d]: got %0d expected 7", i, outSum); end
      checks++; if (outCount !== 8'd2) begin errors++; $display("[TB] FAIL hold_count[%0d]: got %0d expected 2", i, outCount); end
      @(posedge clk);
      #1;
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL hold_release: got %0h expected 0", outValid); end
    drive(32'd8, 1'b1);
    inValid = 1'b0;
    checks++; if (outSum !== 40'd8) begin errors++; $display("[TB] FAIL hold_next_sum: got %0d expected 8", outSum); end
    checks++; if (outCount !== 8'd1) begin errors++; $display("[TB] FAIL hold_next_count: got %0d expected 1", outCount); end
    idle(1);
  endtask

  task automatic test_overflow();
    logic [32:0] exp33a;
    logic [32:0] exp33b;
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
    exp33a = 33'h1_FFFF_FFFF;
    exp33b = 33'h1_FFFF_FFFF;
`else
    exp33a = 33'h0_0000_0000;
    exp33b = 33'h0_0000_0005;
`endif
    outReady = 1'b1;
    drive(32'hFFFF_FFFF, 1'b0);
    drive(32'hFFFF_FFFF, 1'b0);
    drive(32'd2, 1'b1);
    inValid = 1'b0;
    checks++; if (outSum33 !== exp33a) begin errors++; $display("[TB] FAIL ovf33_sum: got %0h expected %0h", outSum33, exp33a); end
    checks++; if (outOvf33 !== 1'b1) begin errors++; $display("[TB] FAIL ovf33_flag: got %0h expected 1", outOvf33); end
    checks++; if (outCount33 !== 8'd3) begin errors++; $display("[TB] FAIL ovf33_count: got %0d expected 3", outCount33); end
    checks++; if (outSum !== 40'h02_0000_0000) begin errors++; $display("[TB] FAIL ovf40_sum: got %0h expected 200000000", outSum); end
    checks++; if (outOvf !== 1'b0) begin errors++; $display("[TB] FAIL ovf40_flag: got %0h expected 0", outOvf); end
    idle(1);
    // A beat after the carry shows stickiness of the flag and of saturation.
    drive(32'hFFFF_FFFF, 1'b0);
    drive(32'hFFFF_FFFF, 1'b0);
    drive(32'd2, 1'b0);
    drive(32'd5, 1'b1);
    inValid = 1'b0;
    checks++; if (outSum33 !== exp33b) begin errors++; $display("[TB] FAIL sticky33_sum: got %0h expected %0h", outSum33, exp33b); end
    checks++; if (outOvf33 !== 1'b1) begin errors++; $display("[TB] FAIL sticky33_flag: got %0h expected 1", outOvf33); end
    checks++; if (outSum !== 40'h02_0000_0005) begin errors++; $display("[TB] FAIL sticky40_sum: got %0h expected 200000005", outSum); end
    idle(1);
    drive(32'd1, 1'b1);
    inValid = 1'b0;
    checks++; if (outSum33 !== 33'd1) begin errors++; $display("[TB] FAIL ovf_clean_sum: got %0h expected 1", outSum33); end
    checks++; if (outOvf33 !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clean_flag: got %0h expected 0", outOvf33); end
    idle(1);
  endtask

  task automatic test_count_saturation();
    logic [39:0] expSum;
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
    expSum = 40'hFF_FFFF_FFFF;
`else
    expSum = 40'h00_FFFF_FEFF;
`endif
    outReady = 1'b1;
    // 257 * (2^32-1) = 2^40 + 2^32 - 257: overflows 40 bits, count clamps at 255.
    for (int i = 0; i < 256; i++) begin
      drive(32'hFFFF_FFFF, 1'b0);
    end
    drive(32'hFFFF_FFFF, 1'b1);
    inValid = 1'b0;
    checks++; if (outCount !== 8'd255) begin errors++; $display("[TB] FAIL cnt_sat_count: got %0d expected 255", outCount); end
    checks++; if (outOvf !== 1'b1) begin errors++; $display("[TB] FAIL cnt_sat_ovf: got %0h expected 1", outOvf); end
    checks++; if (outSum !== expSum) begin errors++; $display("[TB] FAIL cnt_sat_sum: got %0h expected %0h", outSum, expSum); end
    idle(1);
  endtask

  task automatic test_clear();
    outReady = 1'b1;
    drive(32'd10, 1'b0);
    drive(32'd20, 1'b0);
    clear = 1'b1;
    drive(32'd30, 1'b1);
    clear   = 1'b0;
    inValid = 1'b0;
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL clear_no_output: got %0h expected 0", outValid); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL clear_ready: got %0h expected 1", inReady); end
    idle(2);
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL clear_still_idle: got %0h expected 0", outValid); end
    drive(32'd1, 1'b1);
    inValid = 1'b0;
    checks++; if (outSum !== 40'd1) begin errors++; $display("[TB] FAIL clear_next_sum: got %0d expected 1", outSum); end
    checks++; if (outCount !== 8'd1) begin errors++; $display("[TB] FAIL clear_next_count: got %0d expected 1", outCount); end
    idle(1);
    // Clear while a result is pending.
    outReady = 1'b0;
    drive(32'd2, 1'b1);
    inValid = 1'b0;
    checks++; if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL clear_hold_valid: got %0h expected 1", outValid); end
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL clear_hold_drop: got %0h expected 0", outValid); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL clear_hold_ready: got %0h expected 1", inReady); end
    checks++; if (outSum !== 40'd2) begin errors++; $display("[TB] FAIL clear_hold_sum_kept: got %0d expected 2", outSum); end
    outReady = 1'b1;
    drive(32'd3, 1'b1);
    inValid = 1'b0;
    checks++; if (outSum !== 40'd3) begin errors++; $display("[TB] FAIL clear_hold_next_sum: got %0d expected 3", outSum); end
    checks++; if (outCount !== 8'd1) begin errors++; $display("[TB] FAIL clear_hold_next_count: got %0d expected 1", outCount); end
    idle(1);
  endtask

  task automatic test_async_reset();
    outReady = 1'b1;
    drive(32'd50, 1'b0);
    drive(32'd60, 1'b0);
    inValid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (outSum !== 40'd0) begin errors++; $display("[TB] FAIL areset_sum: got %0d expected 0", outSum); end
    checks++; if (outCount !== 8'd0) begin errors++; $display("[TB] FAIL areset_count: got %0d expected 0", outCount); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL areset_valid: got %0h expected 0", outValid); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    drive(32'd4, 1'b1);
    inValid = 1'b0;
    checks++; if (outSum !== 40'd4) begin errors++; $display("[TB] FAIL areset_next_sum: got %0d expected 4", outSum); end
    checks++; if (outCount !== 8'd1) begin errors++; $display("[TB] FAIL areset_next_count: got %0d expected 1", outCount); end
    idle(1);
    // Reset while a result is held.
    outReady = 1'b0;
    drive(32'd9, 1'b1);
    inValid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL areset_hold_valid: got %0h expected 0", outValid); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL areset_hold_ready: got %0h expected 1", inReady); end
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    outReady = 1'b1;
    idle(1);
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    inValid   = 1'b0;
    inProduct = 32'd0;
    inLast    = 1'b0;
    outReady  = 1'b1;
    $display("[TB] product_accumulator directed tests");
    test_reset();
    test_basic();
    test_single();
    test_gaps();
    test_back_to_back_hold();
    test_overflow();
    test_count_saturation();
    test_clear();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
